fc_neuron_stream: RTL
=====================

# fc_neuron_stream

Parametrised fully-connected neuron for the CNN classifier head. It computes one output as a dot product of N_IN activations and N_IN weights, plus bias. Operands arrive as a stream of LANES-wide beats with a valid/ready handshake, so the wide parallel operand ports of the fixed 3136-input generation are not needed. It adds optional ReLU and output saturation. Instances sit between the flatten/activation buffer and the final argmax/classifier stage, one per output neuron or time-shared by a controller.

## Interface
Parameters:
- N_IN, 3136, number of activation/weight pairs per neuron; must be a multiple of LANES
- LANES, 4, products accumulated per accepted beat
- IN_W, 30, signed activation width
- W_W, 9, signed weight width
- B_W, 9, signed bias width
- OUT_W, 38, signed output width; result saturates to this width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a new neuron computation; accepted only in IDLE
- relu_en  in  1  sampled with start; 1 clamps negative results to 0
- b  in  B_W  signed bias; sampled with start
- in_valid  in  1  beat valid
- in_ready  out  1  block accepts a beat
- x  in  LANES*IN_W  packed signed activations; lane 0 in the LSBs
- w  in  LANES*W_W  packed signed weights; lane 0 in the LSBs
- out_valid  out  1  y is valid
- out_ready  in  1  consumer accepts y
- y  out  OUT_W  signed result
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after y is consumed

## Operation
- Accumulator width: ACC_W = IN_W + W_W + clog2(N_IN) + 1. It never overflows internally.
- States and transitions:
  - IDLE: start=1 → ACC. The same edge clears the accumulator and beat counter and latches b and relu_en.
  - ACC: in_ready=1. Each beat with in_valid & in_ready adds the sum of LANES signed products x[i]*w[i], computed full-width. The beat counter increments on each accepted beat. Accepting beat N_IN/LANES-1 → FIN.
  - FIN: in_ready=0. Computes r = acc + sign-extended b. If relu_en and r<0, r=0. r is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and registered into y. → OUT.
  - OUT: out_valid=1 and y held stable until out_ready=1. On that edge → IDLE, and done=1 for the following cycle.
- start outside IDLE is ignored. It is not queued.
- in_valid outside ACC is ignored. No beat is consumed.
- Beats may stall: in_valid=0 in ACC adds nothing and the counter holds.
- rst, in any state: → IDLE. acc=0, counter=0, y=0, out_valid=0, in_ready=0, busy=0, done=0. An in-flight computation is discarded.
- rst and start in the same cycle: rst wins.

## Timing
- Reset values: in_ready=0, out_valid=0, y=0, busy=0, done=0.
- start at edge t: in_ready=1 from cycle t+1.
- Last beat accepted at edge t: out_valid=1 from cycle t+2 (one cycle in FIN).
- Minimum total latency from start to out_valid: N_IN/LANES + 2 cycles with no stalls.
- out_ready already high when out_valid rises: handoff completes in one cycle, and done pulses the next cycle. start may be asserted in that done cycle (state is IDLE).
- in_ready and out_valid are registered. No combinational path exists from in_valid or out_ready to any output.

## Structure
- Shared package fc_pkg holds:
  - state enum (IDLE, ACC, FIN, OUT)
  - function computing ACC_W
  - saturate(value, width) function shared with other fc blocks
- One sub-module, fc_lane_dot: a combinational signed adder tree summing LANES products. Output width is IN_W+W_W+clog2(LANES). It is reused by future multi-neuron layers.
- Top holds the FSM, beat counter, accumulator, bias/ReLU/saturation, and output register.

## Test plan
Bench config: N_IN=4, LANES=2, OUT_W=38 unless stated.
- Basic: x={1,2,3,4}, w={1,1,1,1}, b=5, relu_en=0, no stalls → y=15; out_valid at start+4 cycles; done one cycle after out_ready.
- ReLU: x={-10,0,0,0}, w={1,0,0,0}, b=2. relu_en=0 → y=-8; relu_en=1 → y=0.
- Saturation with OUT_W=8: x={100,100,0,0}, w={2,2,0,0}, b=0 → y=127. Negated weights → y=-128.
- Back-pressure and stalls: in_valid toggled 1,0,0,1 and out_ready held low 5 cycles → y correct, y and out_valid stable while held, in_ready=0 in FIN and OUT.
- Reset mid-ACC after one beat, then a fresh start with x={1,1,1,1}, w={1,1,1,1}, b=0 → all outputs 0 after reset; y=4, with no residue from the aborted run.
- Start ignored while busy: start pulses during ACC and OUT → exactly one result and one done.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully-connected (fc) classifier blocks.
//   fc_state_e  - neuron controller states
//   acc_width() - accumulator width that cannot overflow for a given neuron
//   saturate()  - clamp a wide signed value into a signed field of 'width' bits
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } fc_state_e;

    // Widest intermediate handled by saturate(); callers sign-extend into it.
    localparam int unsigned SAT_W = 128;

    function automatic int acc_width(input int in_w, input int w_w, input int n_in);
        return in_w + w_w + $clog2(n_in) + 1;
    endfunction

    // Result is sign-extended to SAT_W; callers keep the low 'width' bits.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                         input int unsigned width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        // 0111..1 shifted right leaves exactly width-1 ones: 2^(width-1)-1.
        hi = $signed({1'b0, {(SAT_W-1){1'b1}}}) >>> (SAT_W - width);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fc_lane_dot.sv
// fc_lane_dot: combinational signed dot product of LANES activation/weight pairs.
//   x_i   - LANES packed signed activations (IN_W each), lane 0 in the LSBs
//   w_i   - LANES packed signed weights (W_W each), lane 0 in the LSBs
//   sum_o - signed sum of products, IN_W+W_W+clog2(LANES) bits, never overflows
module fc_lane_dot #(
    parameter int LANES = 4,
    parameter int IN_W  = 30,
    parameter int W_W   = 9
) (
    input  logic [LANES*IN_W-1:0]                 x_i,
    input  logic [LANES*W_W-1:0]                  w_i,
    output logic [IN_W+W_W+$clog2(LANES)-1:0]     sum_o
);

    localparam int PROD_W = IN_W + W_W;
    localparam int SUM_W  = IN_W + W_W + $clog2(LANES);

    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [SUM_W-1:0]  sum_c;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod[i] = $signed(x_i[i*IN_W +: IN_W]) * $signed(w_i[i*W_W +: W_W]);
        end
    end

    // Written as a linear chain; synthesis rebalances it into a tree.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_c = sum_c + SUM_W'(prod[i]);
        end
    end

    assign sum_o = sum_c;

endmodule

// File: rtl/fc_neuron_stream.sv
// fc_neuron_stream: one fully-connected neuron, y = sat(relu(sum(x*w) + b)).
// Operands stream in as LANES-wide beats; N_IN/LANES beats make one neuron.
//   clk, rst             - clock, synchronous active-high reset
//   start, relu_en, b    - begin computation (IDLE only); ReLU enable and bias latched with start
//   in_valid/in_ready    - operand beat handshake; x, w hold LANES packed signed lanes
//   out_valid/out_ready  - result handshake; y is the saturated OUT_W-bit result
//   busy                 - not IDLE
//   done                 - one-cycle pulse after y is consumed
module fc_neuron_stream
    import fc_pkg::*;
#(
    parameter int N_IN  = 3136,
    parameter int LANES = 4,
    parameter int IN_W  = 30,
    parameter int W_W   = 9,
    parameter int B_W   = 9,
    parameter int OUT_W = 38
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [B_W-1:0]        b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] x,
    input  logic [LANES*W_W-1:0]  w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      y,
    output logic                  busy,
    output logic                  done
);

    localparam int ACC_W = acc_width(IN_W, W_W, N_IN);
    localparam int DOT_W = IN_W + W_W + $clog2(LANES);
    localparam int BEATS = N_IN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    fc_state_e               state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [B_W-1:0]   b_q, b_d;
    logic                    relu_q, relu_d;
    logic [OUT_W-1:0]        y_q, y_d;
    logic                    done_q, done_d;

    logic signed [DOT_W-1:0] dot;
    logic signed [SAT_W-1:0] res;
    logic signed [SAT_W-1:0] res_sat;

    fc_lane_dot #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .W_W   (W_W)
    ) u_dot (
        .x_i   (x),
        .w_i   (w),
        .sum_o (dot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            relu_q  <= 1'b0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            relu_q  <= relu_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        relu_d  = relu_q;
        y_d     = y_q;
        done_d  = 1'b0;
        res     = SAT_W'(acc_q) + SAT_W'(b_q);
        if (relu_q && res[SAT_W-1]) begin
            res = '0;
        end
        res_sat = saturate(res, OUT_W);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    b_d     = $signed(b);
                    relu_d  = relu_en;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = acc_q + ACC_W'(dot);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                y_d     = res_sat[OUT_W-1:0];
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode registered state only: no path from in_valid/out_ready.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign y         = y_q;

endmodule
